l2_line_merge_ctrl: RTL
=======================

L2_LINE_MERGE_CTRL -- requirements
Module: l2_line_merge_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single clock, all state rising-edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: load_valid in 1, load_ready out 1, load_line in line_t; these load the base line.
REQ-004 SHALL have ports: wr_valid in 2 and wr_ready out 2; one bit per requester (0 = CPU store, 1 = forward/ext).
REQ-005 SHALL have per-requester write ports: wr_word in 2 x word_t, wr_w_off in 2 x word_offset_t, wr_b_off in 2 x byte_offset_t, wr_hsize in 2 x hsize_t.
REQ-006 SHALL have port: flush_req in 1; a request to emit the merged line.
REQ-007 SHALL have ports: out_valid out 1, out_ready in 1, out_line out line_t, out_dirty out WORDS_PER_LINE (per-word written mask).
REQ-008 SHALL have ports: busy out 1 (state != IDLE) and wr_cnt out 8 (accepted writes this line).

Function
REQ-009 SHALL implement FSM states IDLE, MERGE and FLUSH.
REQ-010 In IDLE, SHALL drive load_ready=1; on load_valid&&load_ready it SHALL capture load_line into the line register, clear out_dirty and wr_cnt, and go to MERGE.
REQ-011 In MERGE, SHALL assert at most one wr_ready bit per cycle, and only for the requester that is granted and valid.
REQ-012 Arbitration SHALL be round-robin over a 1-bit priority pointer: if both requesters are valid, the pointer side wins; if one is valid, that one wins; the pointer SHALL flip to the other requester after each accepted write.
REQ-013 An accepted write (wr_valid[i]&&wr_ready[i]) SHALL merge into the line register at the next clock edge: one-cycle latency, byte-lane merge selected by hsize/w_off/b_off (BYTE 8b, HALFWORD 16b, WORD_32 32b, else full word), leaving untouched bits unchanged.
REQ-014 An accepted write SHALL set out_dirty[w_off] and increment wr_cnt, which saturates at 255.
REQ-015 If flush_req is high in MERGE, SHALL go to FLUSH at the next edge; a write accepted in the same cycle SHALL still be merged and be visible in out_line.
REQ-016 In IDLE and FLUSH, SHALL hold wr_ready=0 and ignore writes.
REQ-017 In FLUSH, SHALL hold out_valid=1 and keep out_line/out_dirty stable until out_ready; on out_valid&&out_ready it SHALL go to IDLE.
REQ-018 flush_req SHALL be ignored outside MERGE; load_valid SHALL be ignored outside IDLE.
REQ-019 Writes to the same word in back-to-back cycles SHALL each apply in order, the later one overwriting overlapping bytes.
REQ-020 out_line SHALL be the line register directly (registered output), with no combinational path from wr_* to out_*.

Reset
REQ-021 On rst low, asynchronously and regardless of state: state=IDLE, line register=0, out_dirty=0, wr_cnt=0, priority pointer=0, out_valid=0, wr_ready=0, busy=0.
REQ-022 After reset release, load_ready SHALL be 1; reset during MERGE or FLUSH SHALL discard the line without emitting it.

Structure
REQ-023 line_t, word_t, word_offset_t, byte_offset_t, hsize_t, WORDS_PER_LINE, BITS_PER_WORD and the hsize encodings SHALL come from the shared spandex consts/types package; FSM state enum SHALL also be placed there.
REQ-024 The byte-lane merge SHALL be one instance of the existing combinational l2_write_word sub-module, fed by a mux on the granted requester; arbitration stays inline.

Verification (config BITS_PER_WORD=64, WORDS_PER_LINE=2, little-endian)
REQ-025 Load 0, then req0 BYTE 0xAB at w_off=1,b_off=3, then flush -> out_line[95:88]=0xAB, all other bits 0, out_dirty=2'b10, wr_cnt=1.
REQ-026 Both valid continuously for 4 cycles after reset -> grants 0,1,0,1, one wr_ready bit per cycle, wr_cnt=4.
REQ-027 Accepted WORD_32 0xDEADBEEF at w_off=0,b_off=0 in the same cycle as flush_req -> FLUSH next cycle with out_line[31:0]=0xDEADBEEF.
REQ-028 Hold out_ready=0 for 5 cycles in FLUSH while wr_valid=2'b11 -> out_valid stays 1, out_line stable, wr_ready=0 throughout.
REQ-029 Apply 300 accepted writes -> wr_cnt=255; assert rst mid-MERGE -> next cycle state IDLE, out_dirty=0, wr_cnt=0, load_ready=1.
REQ-030 HALFWORD 0x1234 then BYTE 0xFF at the same w_off=0,b_off=0 on back-to-back cycles -> out_line[15:0]=0x12FF.

Source files
------------

// File: rtl/l2_line_merge_ctrl_pkg.sv
// Shared line/word types, hsize encodings and merge-controller FSM states.
package l2_line_merge_ctrl_pkg;

  localparam int BITS_PER_WORD    = 64;
  localparam int WORDS_PER_LINE   = 2;
  localparam int WORD_OFFSET_BITS = 1;
  localparam int BYTE_OFFSET_BITS = 3;

  typedef logic [BITS_PER_WORD-1:0]                line_word_unused_t;
  typedef logic [BITS_PER_WORD-1:0]                word_t;
  typedef logic [WORDS_PER_LINE*BITS_PER_WORD-1:0] line_t;
  typedef logic [WORD_OFFSET_BITS-1:0]             word_offset_t;
  typedef logic [BYTE_OFFSET_BITS-1:0]             byte_offset_t;
  typedef logic [2:0]                              hsize_t;

  localparam hsize_t BYTE     = 3'b000;
  localparam hsize_t HALFWORD = 3'b001;
  localparam hsize_t WORD_32  = 3'b010;
  localparam hsize_t WORD_64  = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    FLUSH = 2'd2
  } merge_state_t;

endpackage

// File: rtl/l2_write_word.sv
// Combinational byte-lane merge of one word into a cache line.
module l2_write_word
  import l2_line_merge_ctrl_pkg::*;
(
  input  line_t        line_i,
  input  word_t        word_i,
  input  word_offset_t w_off_i,
  input  byte_offset_t b_off_i,
  input  hsize_t       hsize_i,
  output line_t        line_o
);

  word_t      mask;
  word_t      mask_sh;
  word_t      data_sh;
  word_t      old_w;
  logic [5:0] shamt;

  always_comb begin
    case (hsize_i)
      BYTE:     mask = word_t'(8'hFF);
      HALFWORD: mask = word_t'(16'hFFFF);
      WORD_32:  mask = word_t'(32'hFFFF_FFFF);
      default:  mask = '1;
    endcase
    // Source data sits in the low bits of the word; it is moved up to its byte lane.
    shamt   = {b_off_i, 3'b000};
    mask_sh = mask << shamt;
    data_sh = word_i << shamt;
    old_w   = line_i[w_off_i*BITS_PER_WORD +: BITS_PER_WORD];
    line_o  = line_i;
    line_o[w_off_i*BITS_PER_WORD +: BITS_PER_WORD] = (old_w & ~mask_sh) | (data_sh & mask_sh);
  end

endmodule

// File: rtl/l2_line_merge_ctrl.sv
// Loads a base line, merges arbitrated partial writes from two requesters, emits on flush.
module l2_line_merge_ctrl
  import l2_line_merge_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  line_t                     load_line,
  input  logic [1:0]                wr_valid,
  output logic [1:0]                wr_ready,
  input  word_t [1:0]               wr_word,
  input  word_offset_t [1:0]        wr_w_off,
  input  byte_offset_t [1:0]        wr_b_off,
  input  hsize_t [1:0]              wr_hsize,
  input  logic                      flush_req,
  output logic                      out_valid,
  input  logic                      out_ready,
  output line_t                     out_line,
  output logic [WORDS_PER_LINE-1:0] out_dirty,
  output logic                      busy,
  output logic [7:0]                wr_cnt
);

  merge_state_t              state_q, state_d;
  line_t                     line_q, line_d;
  logic [WORDS_PER_LINE-1:0] dirty_q, dirty_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      ptr_q, ptr_d;
  logic                      gnt;
  logic                      accept;
  line_t                     merged;

  // Round-robin: pointer side wins a tie, a lone requester always wins.
  always_comb begin
    gnt = ptr_q;
    if (wr_valid == 2'b01)      gnt = 1'b0;
    else if (wr_valid == 2'b10) gnt = 1'b1;
    accept   = (state_q == MERGE) && (|wr_valid);
    wr_ready = accept ? (2'b01 << gnt) : 2'b00;
  end

  l2_write_word u_write_word (
    .line_i  (line_q),
    .word_i  (wr_word[gnt]),
    .w_off_i (wr_w_off[gnt]),
    .b_off_i (wr_b_off[gnt]),
    .hsize_i (wr_hsize[gnt]),
    .line_o  (merged)
  );

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    dirty_d    = dirty_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    load_ready = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          line_d  = load_line;
          dirty_d = '0;
          cnt_d   = '0;
          state_d = MERGE;
        end
      end
      MERGE: begin
        if (accept) begin
          line_d                 = merged;
          dirty_d[wr_w_off[gnt]] = 1'b1;
          cnt_d                  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          ptr_d                  = ~gnt;
        end
        if (flush_req) state_d = FLUSH;
      end
      FLUSH: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      line_q  <= '0;
      dirty_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      dirty_q <= dirty_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_line  = line_q;
  assign out_dirty = dirty_q;
  assign wr_cnt    = cnt_q;
  assign busy      = (state_q != IDLE);

endmodule
